// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor reusing one BITS_PER_CYCLE-wide slice across WIDTH bits, LSB slice first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int BPC = BITS_PER_CYCLE;
   localparam int N   = (BPC > 0) ? WIDTH / BPC : 1;
   localparam int CW  = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
         $error("serial_adder: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic [BPC:0]     slice;
   logic [WIDTH-1:0] result;
   logic             last;

   assign slice = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
   assign last  = (cnt_q == CW'(N - 1));

   // result holds the newest slice on top of all earlier slices; on the last slice it is the full sum
   generate
      if (N > 1) begin : g_psum
         logic [WIDTH-BPC-1:0] psum_q;
         always_ff @(posedge clk) begin
            if (state_q == RUN) psum_q <= result[WIDTH-1:BPC];
         end
         assign result = {slice[BPC-1:0], psum_q};
      end else begin : g_nopsum
         assign result = slice[BPC-1:0];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = cin ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> BPC;
            b_d     = b_q >> BPC;
            carry_d = slice[BPC];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               sum_d   = result;
               cout_d  = slice[BPC];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
   end

`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB is recovered from the MSB's sum bit and its two operand bits
   logic ovf_q, ovf_d;
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == RUN && last)
         ovf_d = (slice[BPC-1] ^ a_q[BPC-1] ^ b_q[BPC-1]) ^ slice[BPC];
   end
   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, handshake/reset sequences, and a 16-bit sweep.
// Instances 0..1 are WIDTH=8 (BPC 1,4); instances 2..6 are WIDTH=16 (BPC 1,2,4,8,16).
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [6:0]  start_v, cin_v, sub_v, busy_v, done_v, cout_v;
   logic [7:0]  a8[2], b8[2], sum8[2];
   logic [15:0] a16[5], b16[5], sum16[5];
`ifdef SERIAL_ADDER_OVF_EN
   logic [6:0]  ovf_v;
`endif

   int n_chk = 0;
   int n_err = 0;

   function automatic int bof(input int g);
      case (g)
         0: return 1;
         1: return 4;
         2: return 1;
         3: return 2;
         4: return 4;
         5: return 8;
         default: return 16;
      endcase
   endfunction

   generate
      for (genvar g = 0; g < 2; g++) begin : g_w8
         serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(bof(g))) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .a(a8[g]), .b(b8[g]),
            .cin(cin_v[g]), .sub(sub_v[g]), .busy(busy_v[g]), .done(done_v[g]),
            .sum(sum8[g]), .cout(cout_v[g])
`ifdef SERIAL_ADDER_OVF_EN
            , .ovf(ovf_v[g])
`endif
         );
      end
      for (genvar g = 0; g < 5; g++) begin : g_w16
         serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(bof(g + 2))) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g+2]), .a(a16[g]), .b(b16[g]),
            .cin(cin_v[g+2]), .sub(sub_v[g+2]), .busy(busy_v[g+2]), .done(done_v[g+2]),
            .sum(sum16[g]), .cout(cout_v[g+2])
`ifdef SERIAL_ADDER_OVF_EN
            , .ovf(ovf_v[g+2])
`endif
         );
      end
   endgenerate

   function automatic logic [15:0] get_sum(input int i);
      if (i < 2) return {8'h00, sum8[i]};
      return sum16[i-2];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge, then scrambles operands.
   task automatic launch(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb);
      if (i < 2) begin a8[i] = a[7:0]; b8[i] = b[7:0]; end
      else       begin a16[i-2] = a;   b16[i-2] = b;   end
      cin_v[i] = ci; sub_v[i] = sb; start_v[i] = 1'b1;
      @(posedge clk); #1;
      start_v[i] = 1'b0;
      if (i < 2) begin a8[i] = ~a[7:0]; b8[i] = ~b[7:0]; end
      else       begin a16[i-2] = ~a;   b16[i-2] = ~b;   end
      cin_v[i] = ~ci; sub_v[i] = ~sb;
   endtask

   task automatic wait_done(input int i, output int cyc, output int bcnt);
      cyc  = 0;
      bcnt = busy_v[i] ? 1 : 0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (done_v[i]) return;
         if (busy_v[i]) bcnt++;
      end
      cyc = -1;
   endtask

   function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
      logic [31:0] m, r;
      logic        co;
      m = (32'd1 << w) - 32'd1;
      if (!sb) begin
         r  = {16'h0, a} + {16'h0, b} + {31'h0, ci};
         co = r[w];
      end else begin
         r  = {16'h0, a} - {16'h0, b} - {31'h0, ci};
         co = ({16'h0, a} >= ({16'h0, b} + {31'h0, ci}));
      end
      r = r & m;
      return {co, r[15:0]};
   endfunction

`ifdef SERIAL_ADDER_OVF_EN
   function automatic logic ovf_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                      input logic ci, input logic sb);
      logic [31:0] m, lm, bb, c, lo, full;
      m    = (32'd1 << w) - 32'd1;
      lm   = (32'd1 << (w - 1)) - 32'd1;
      bb   = sb ? (~{16'h0, b} & m) : {16'h0, b};
      c    = {31'h0, ci ^ sb};
      lo   = ({16'h0, a} & lm) + (bb & lm) + c;
      full = {16'h0, a} + bb + c;
      return lo[w-1] ^ full[w];
   endfunction
`endif

   typedef struct {
      int          i;
      logic [15:0] a, b;
      logic        ci, sb;
      logic [15:0] es;
      logic        ec, eo;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int          cyc, bc, seen;
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [16:0] exp;

      tbl[0] = '{0, 16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1, 8};
      tbl[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8};
      tbl[2] = '{0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 8};
      tbl[3] = '{0, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0, 8};
      tbl[4] = '{1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 2};
      tbl[5] = '{1, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 2};
      tbl[6] = '{6, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1};
      tbl[7] = '{2, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16};

      rst = 1'b1; start_v = '0; cin_v = '0; sub_v = '0;
      for (int i = 0; i < 2; i++) begin a8[i] = '0; b8[i] = '0; end
      for (int i = 0; i < 5; i++) begin a16[i] = '0; b16[i] = '0; end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         chk($sformatf("reset_busy[%0d]", i), {31'h0, busy_v[i]}, 32'h0);
         chk($sformatf("reset_done[%0d]", i), {31'h0, done_v[i]}, 32'h0);
         chk($sformatf("reset_sum[%0d]", i),  {16'h0, get_sum(i)}, 32'h0);
         chk($sformatf("reset_cout[%0d]", i), {31'h0, cout_v[i]}, 32'h0);
      end

      for (int t = 0; t < 8; t++) begin
         launch(tbl[t].i, tbl[t].a, tbl[t].b, tbl[t].ci, tbl[t].sb);
         wait_done(tbl[t].i, cyc, bc);
         chk($sformatf("vec%0d_latency", t), cyc, tbl[t].lat);
         chk($sformatf("vec%0d_busy_cycles", t), bc, tbl[t].lat);
         chk($sformatf("vec%0d_sum", t), {16'h0, get_sum(tbl[t].i)}, {16'h0, tbl[t].es});
         chk($sformatf("vec%0d_cout", t), {31'h0, cout_v[tbl[t].i]}, {31'h0, tbl[t].ec});
`ifdef SERIAL_ADDER_OVF_EN
         if (tbl[t].i != 0)
            chk($sformatf("vec%0d_ovf", t), {31'h0, ovf_v[tbl[t].i]}, {31'h0, tbl[t].eo});
`endif
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_one_cycle", t), {31'h0, done_v[tbl[t].i]}, 32'h0);
      end

      // start while busy must be ignored
      launch(0, 16'h0012, 16'h0034, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      a8[0] = 8'hFF; b8[0] = 8'hFF; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_done(0, cyc, bc);
      chk("ignore_start_latency", cyc + 3, 8);
      chk("ignore_start_sum", {16'h0, get_sum(0)}, 32'h46);

      // back-to-back: start accepted during the done cycle
      @(posedge clk); #1;
      launch(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done(0, cyc, bc);
      chk("b2b_first_sum", {16'h0, get_sum(0)}, 32'h02);
      launch(0, 16'h0020, 16'h0003, 1'b0, 1'b0);
      wait_done(0, cyc, bc);
      chk("b2b_second_latency", cyc, 8);
      chk("b2b_second_sum", {16'h0, get_sum(0)}, 32'h23);

      // reset in the middle of an operation
      @(posedge clk); #1;
      launch(0, 16'h005A, 16'h003C, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midreset_busy", {31'h0, busy_v[0]}, 32'h0);
      chk("midreset_done", {31'h0, done_v[0]}, 32'h0);
      chk("midreset_sum",  {16'h0, get_sum(0)}, 32'h0);
      chk("midreset_cout", {31'h0, cout_v[0]}, 32'h0);
      seen = 0;
      repeat (12) begin @(posedge clk); #1; if (done_v[0]) seen++; end
      chk("midreset_no_done", seen, 0);
      launch(0, 16'h0001, 16'h0002, 1'b0, 1'b0);
      wait_done(0, cyc, bc);
      chk("after_reset_latency", cyc, 8);
      chk("after_reset_sum", {16'h0, get_sum(0)}, 32'h03);

      // 16-bit sweep across every slice width
      for (int g = 2; g < 7; g++) begin
         for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            if (n == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; rs = 1'b0; end
            if (n == 1) begin ra = 16'h0000; rb = 16'hFFFF; rc = 1'b1; rs = 1'b1; end
            exp = model(16, ra, rb, rc, rs);
            launch(g, ra, rb, rc, rs);
            wait_done(g, cyc, bc);
            chk($sformatf("sweep_bpc%0d_n%0d_latency", bof(g), n), cyc, 16 / bof(g));
            chk($sformatf("sweep_bpc%0d_n%0d_sum", bof(g), n), {16'h0, get_sum(g)}, {16'h0, exp[15:0]});
            chk($sformatf("sweep_bpc%0d_n%0d_cout", bof(g), n), {31'h0, cout_v[g]}, {31'h0, exp[16]});
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("sweep_bpc%0d_n%0d_ovf", bof(g), n), {31'h0, ovf_v[g]},
                {31'h0, ovf_model(16, ra, rb, rc, rs)});
`endif
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
